radix4_div24: RTL and testbench



---
 rtl/radix4_div24.sv | 166 ++++++++++++++++
 tb/tb_radix4_div24.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/radix4_div24.sv
// Sequential 24-bit signed/unsigned radix-4 restoring divider, two quotient bits per clock.
// Optional macro RADIX4_DIV24_ZERO_FAST_EN: zero divisor bypasses CALC/FIXUP (IDLE -> DONE).
module radix4_div24 (
    input  logic        clk,
    input  logic        rst,
    input  logic        signedFlag,
    input  logic [23:0] dividend,
    input  logic [23:0] divisor,
    input  logic        inValid,
    output logic        inReady,
    output logic [23:0] quotient,
    output logic [23:0] remainder,
    output logic        divZero,
    output logic        outValid,
    input  logic        outReady
);

    localparam int unsigned W    = 24;
    localparam int unsigned PRW  = 26;
    localparam int unsigned CW   = 4;
    localparam int unsigned ITER = 12;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [PRW-1:0]   pr;
    logic [W-1:0]     q_acc;
    logic [W-1:0]     dvd_sh;
    logic [W-1:0]     dvs_mag;
    logic [W-1:0]     raw_dvd;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic             accept_c, calc_c, fixup_c, release_c, zero_fast_c;
    logic             neg_dvd_c, neg_dvs_c;
    logic [W-1:0]     dvd_mag_c, dvs_mag_c;
    logic [PRW:0]     pr_sh_c, d1_c, d2_c, d3_c, sub_c;
    logic [1:0]       digit_c;
    logic [PRW-1:0]   pr_nx_c;
    logic [W-1:0]     q_fix_c, r_fix_c;

`ifdef RADIX4_DIV24_ZERO_FAST_EN
    assign zero_fast_c = (divisor == '0);
`else
    assign zero_fast_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (inValid) state_nx = zero_fast_c ? DONE : CALC;
            CALC:    if (cnt == CW'(ITER - 1)) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    if (outReady) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control strobes decoded from the registered state
    always_comb begin
        inReady   = 1'b0;
        accept_c  = 1'b0;
        calc_c    = 1'b0;
        fixup_c   = 1'b0;
        release_c = 1'b0;
        inReady   = (state == IDLE) && !rst;
        accept_c  = inReady && inValid;
        calc_c    = (state == CALC);
        fixup_c   = (state == FIXUP);
        release_c = (state == DONE) && outReady;
    end

    // Operand magnitudes and result sign rules (remainder follows dividend)
    always_comb begin
        neg_dvd_c = signedFlag & dividend[W-1];
        neg_dvs_c = signedFlag & divisor[W-1];
        dvd_mag_c = neg_dvd_c ? -dividend : dividend;
        dvs_mag_c = neg_dvs_c ? -divisor  : divisor;
    end

    // One radix-4 digit: largest k in 0..3 with k*d <= shifted PR
    always_comb begin
        pr_sh_c = (PRW+1)'({pr, dvd_sh[W-1 -: 2]});
        d1_c    = (PRW+1)'(dvs_mag);
        d2_c    = d1_c << 1;
        d3_c    = d1_c + d2_c;
        digit_c = 2'd0;
        sub_c   = '0;
        if (pr_sh_c >= d3_c) begin
            digit_c = 2'd3;
            sub_c   = d3_c;
        end else if (pr_sh_c >= d2_c) begin
            digit_c = 2'd2;
            sub_c   = d2_c;
        end else if (pr_sh_c >= d1_c) begin
            digit_c = 2'd1;
            sub_c   = d1_c;
        end
        pr_nx_c = PRW'(pr_sh_c - sub_c);
    end

    always_comb begin
        q_fix_c = neg_q ? -q_acc : q_acc;
        r_fix_c = neg_r ? -pr[W-1:0] : pr[W-1:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pr        <= '0;
            q_acc     <= '0;
            dvd_sh    <= '0;
            dvs_mag   <= '0;
            raw_dvd   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            divZero   <= 1'b0;
            outValid  <= 1'b0;
        end else begin
            if (accept_c) begin
                cnt     <= '0;
                pr      <= '0;
                q_acc   <= '0;
                dvd_sh  <= dvd_mag_c;
                dvs_mag <= dvs_mag_c;
                raw_dvd <= dividend;
                neg_q   <= neg_dvd_c ^ neg_dvs_c;
                neg_r   <= neg_dvd_c;
                dz      <= (divisor == '0);
                if (zero_fast_c) begin
                    quotient  <= '1;
                    remainder <= dividend;
                    divZero   <= 1'b1;
                    outValid  <= 1'b1;
                end
            end
            if (calc_c) begin
                pr     <= pr_nx_c;
                q_acc  <= {q_acc[W-3:0], digit_c};
                dvd_sh <= dvd_sh << 2;
                cnt    <= cnt + CW'(1);
            end
            if (fixup_c) begin
                quotient  <= dz ? '1 : q_fix_c;
                remainder <= dz ? raw_dvd : r_fix_c;
                divZero   <= dz;
                outValid  <= 1'b1;
            end
            if (release_c) outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_radix4_div24.sv
// Scoreboard bench for radix4_div24: reference quotient/remainder from native integer division.
module tb_radix4_div24;

    typedef struct packed {
        logic [23:0] q;
        logic [23:0] r;
        logic        dz;
    } exp_t;

`ifdef RADIX4_DIV24_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 14;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        signedFlag;
    logic [23:0] dividend;
    logic [23:0] divisor;
    logic        inValid;
    logic        inReady;
    logic [23:0] quotient;
    logic [23:0] remainder;
    logic        divZero;
    logic        outValid;
    logic        outReady;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    radix4_div24 dut (
        .clk        (clk),
        .rst        (rst),
        .signedFlag (signedFlag),
        .dividend   (dividend),
        .divisor    (divisor),
        .inValid    (inValid),
        .inReady    (inReady),
        .quotient   (quotient),
        .remainder  (remainder),
        .divZero    (divZero),
        .outValid   (outValid),
        .outReady   (outReady)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [23:0] a, input logic [23:0] b);
        exp_t e;
        int   sa, sb;
        if (b == 24'd0) begin
            e.q  = 24'hFFFFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (!sgn) begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end else begin
            sa   = int'($signed(a));
            sb   = int'($signed(b));
            e.q  = 24'(sa / sb);
            e.r  = 24'(sa % sb);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Compare on the negedge before the output handshake edge
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_zero", 32'(divZero), 32'(e.dz));
            end
        end
    end

    task automatic start_op(input logic sgn, input logic [23:0] a, input logic [23:0] b, input bit push);
        int n;
        n = 0;
        while (!inReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!inReady) check("in_ready_timeout", 32'd0, 32'd1);
        signedFlag = sgn;
        dividend   = a;
        divisor    = b;
        inValid    = 1'b1;
        @(posedge clk); #1;
        inValid    = 1'b0;
        signedFlag = 1'($urandom);
        dividend   = 24'($urandom);
        divisor    = 24'($urandom);
        if (push) exp_q.push_back(model(sgn, a, b));
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!outValid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!outValid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic sgn, input logic [23:0] a, input logic [23:0] b);
        int lat;
        start_op(sgn, a, b, 1'b1);
        check("in_ready_busy", 32'(inReady), 32'd0);
        wait_out(lat);
        check("latency", 32'(lat), (b == 24'd0) ? 32'(ZLAT) : 32'd14);
        @(posedge clk); #1;
        check("out_valid_one_cycle", 32'(outValid), 32'd0);
        check("in_ready_after_hs", 32'(inReady), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] q0, r0;
        logic [23:0] ra, rb;
        int          lat;

        rst        = 1'b1;
        inValid    = 1'b0;
        signedFlag = 1'b0;
        dividend   = '0;
        divisor    = '0;
        outReady   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(outValid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_zero", 32'(divZero), 32'd0);
        check("rst_in_ready_low", 32'(inReady), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(inReady), 32'd1);

        run_op(1'b0, 24'd100, 24'd7);
        run_op(1'b1, 24'hFFFF9C, 24'h000007);
        run_op(1'b1, 24'h000064, 24'hFFFFF9);
        run_op(1'b1, 24'h800000, 24'hFFFFFF);
        run_op(1'b0, 24'hFFFFFF, 24'h000001);
        run_op(1'b0, 24'h123456, 24'h000000);
        run_op(1'b1, 24'hFFFF00, 24'h000000);

        for (int i = 0; i < 16; i++) begin
            ra = 24'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 15)) : 24'($urandom);
            run_op(1'($urandom), ra, rb);
        end

        // Backpressure: hold the result, then a back-to-back operation
        outReady = 1'b0;
        start_op(1'b0, 24'd5000, 24'd13, 1'b1);
        wait_out(lat);
        check("bp_latency", 32'(lat), 32'd14);
        q0 = quotient;
        r0 = remainder;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(outValid), 32'd1);
            check("bp_quotient_stable", 32'(quotient), 32'(q0));
            check("bp_remainder_stable", 32'(remainder), 32'(r0));
            check("bp_in_ready", 32'(inReady), 32'd0);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(outValid), 32'd0);
        check("bp_release_ready", 32'(inReady), 32'd1);
        run_op(1'b1, 24'hFFF000, 24'h000123);

        // Reset pulse in the 6th CALC cycle discards the operation
        start_op(1'b0, 24'd1000, 24'd7, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst_pulse_in_ready", 32'(inReady), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 32'(outValid), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_div_zero", 32'(divZero), 32'd0);
        #1 check("abort_in_ready", 32'(inReady), 32'd1);
        run_op(1'b0, 24'd1000, 24'd3);

        repeat (20) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("idle_no_output", 32'(outValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
